// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch definitions: instruction width, sequencer states and fetch-queue entry layout.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

package fetch_ctrl_pkg;

   localparam int unsigned INST_W = `INST_WIDTH;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      IDLE_HALT = 2'd1,
      FAULT     = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
      logic              fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetch entries with a registered head and a flush input.
module fetch_queue
   import fetch_ctrl_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic         i_pop,
   input  fetch_entry_t i_entry,
   output fetch_entry_t o_head,
   output logic         o_valid,
   output logic         o_full
);

   fetch_entry_t r_head;
   fetch_entry_t r_tail;
   logic [1:0]   r_count;

   logic w_pop;
   logic w_push;

   assign w_pop  = i_pop && (r_count != 2'd0);
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         unique case ({w_pop, w_push})
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_head <= i_entry;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_entry;
               end
            end
            2'b10: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd0) begin
                  r_head <= i_entry;
               end else begin
                  r_tail <= i_entry;
               end
               r_count <= r_count + 2'd1;
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

   assign o_head  = r_head;
   assign o_valid = (r_count != 2'd0);
   assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads inst_mem and feeds decode through a 2-entry
// queue, handling redirects, halt requests and misaligned/out-of-range fetch faults.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 1024,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   output logic [$clog2(MEM_SIZE)-1:0] o_imem_addr,
   input  logic [`INST_WIDTH-1:0]      i_imem_inst,
   input  logic                        i_redirect,
   input  logic [31:0]                 i_redirect_pc,
   input  logic                        i_halt,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [`INST_WIDTH-1:0]      o_inst,
   output logic [31:0]                 o_pc,
   output logic                        o_fault,
   output logic                        o_busy
);

   localparam int unsigned ADDR_W = $clog2(MEM_SIZE);

   logic [31:0]  r_pc;
   fetch_state_t r_state;

   logic         w_valid;
   logic         w_full;
   logic         w_pop;
   logic         w_push;
   logic         w_bad_pc;
   fetch_entry_t w_entry;
   fetch_entry_t w_head;

   assign w_pop    = w_valid && i_ready;
   assign w_bad_pc = (r_pc[1:0] != 2'b00) || ((r_pc >> ADDR_W) != 32'd0);
   // Halt beats both normal and fault pushes; redirect beats everything.
   assign w_push   = !i_redirect && (r_state == RUN) && !i_halt && (!w_full || w_pop);

   always_comb begin
      w_entry.pc    = r_pc;
      w_entry.inst  = w_bad_pc ? '0 : i_imem_inst;
      w_entry.fault = w_bad_pc;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc    <= RESET_PC;
         r_state <= RUN;
      end else if (i_redirect) begin
         r_pc    <= i_redirect_pc;
         r_state <= i_halt ? IDLE_HALT : RUN;
      end else begin
         unique case (r_state)
            RUN: begin
               if (i_halt) begin
                  r_state <= IDLE_HALT;
               end else if (w_push) begin
                  if (w_bad_pc) begin
                     r_state <= FAULT;
                  end else begin
                     r_pc <= r_pc + 32'd4;
                  end
               end
            end
            IDLE_HALT: begin
               if (!i_halt) begin
                  r_state <= RUN;
               end
            end
            FAULT: begin
               r_state <= FAULT;
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

   fetch_queue u_fetch_queue (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_redirect),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_entry (w_entry),
      .o_head  (w_head),
      .o_valid (w_valid),
      .o_full  (w_full)
   );

   assign o_imem_addr = r_pc[ADDR_W-1:0];
   assign o_valid     = w_valid;
   assign o_pc        = w_head.pc;
   assign o_inst      = w_head.inst;
   assign o_fault     = w_head.fault;
   assign o_busy      = (r_state != IDLE_HALT) || w_valid;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the core. Owns the PC and drives the inst_mem read address. inst_mem is combinational read, with a byte address of $clog2(MEM_SIZE) bits.
- Captures each {pc, inst} pair into a 2-entry fetch queue and presents it to decode over a valid/ready handshake.
- Handles branch/jump redirects, halt requests and fetch faults (misaligned or out-of-range PC).

Parameters:
- MEM_SIZE, 1024, inst_mem size in bytes; ADDR_W = $clog2(MEM_SIZE).
- RESET_PC, 32'h00000000, PC loaded on reset; must be 4-byte aligned and < MEM_SIZE.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- o_imem_addr  out  ADDR_W  address to inst_mem i_addr; equals pc[ADDR_W-1:0].
- i_imem_inst  in  `INST_WIDTH  data from inst_mem o_inst, valid in the same cycle.
- i_redirect  in  1  redirect request from execute.
- i_redirect_pc  in  32  redirect target.
- i_halt  in  1  level; stop issuing new fetches while high.
- o_valid  out  1  queue head valid.
- i_ready  in  1  decode accepts head.
- o_inst  out  `INST_WIDTH  head instruction.
- o_pc  out  32  head PC.
- o_fault  out  1  head entry is a fetch fault; o_inst is 0 for such an entry.
- o_busy  out  1  state != IDLE_HALT or queue not empty.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - pc = RESET_PC, queue empty, state = RUN.
  - o_valid = 0, o_fault = 0, o_inst = 0, o_pc = 0.
- Queue:
  - 2 entries, each {pc[31:0], inst, fault}.
  - Head is registered. Outputs are driven from the head entry, never from inst_mem combinationally.
- Pop: occurs when o_valid && i_ready.
- Push: occurs when state == RUN and (count < 2 or pop this cycle).
  - Entry = {pc, i_imem_inst, 0}. pc then advances by 4 (32-bit wrap).
  - Fetch-to-o_valid latency is 1 cycle. Sustained throughput is 1 instruction per cycle when i_ready stays high.
- Fault check:
  - Before a push, if pc[1:0] != 0 or pc[31:ADDR_W] != 0, push {pc, 0, 1} instead and move to FAULT.
  - pc does not advance on a fault push.
  - If the queue is full, the fault push waits like a normal push.
- States:
  - RUN: fetch as above. i_halt high moves to IDLE_HALT at the next edge; no push occurs in that cycle.
  - IDLE_HALT: no push. Pops continue. Returns to RUN when i_halt drops.
  - FAULT: no push. Pops continue. Left only by redirect or reset.
- Redirect (highest priority, any state):
  - Queue flushed (count = 0); any pop or push in that cycle is discarded.
  - pc = i_redirect_pc. State = RUN if i_halt is low, otherwise IDLE_HALT.
  - o_valid = 0 in the following cycle. The first post-redirect entry is valid 2 cycles after the redirect edge.
- Simultaneous events:
  - Redirect overrides halt, pop and push.
  - Pop and push on a full queue both occur, so count stays 2.
  - Halt and a fault condition in the same cycle: halt wins and nothing is pushed.
- o_valid is held while !i_ready, and head contents stay stable until popped or flushed.
- Reset mid-operation discards all queue contents; there is no partial-state carryover.

Decomposition:
- Add to the shared defs package (alongside `INST_WIDTH): fetch_state_t enum {RUN, IDLE_HALT, FAULT} and a fetch_entry_t struct {pc, inst, fault}.
- One sub-module, fetch_queue: 2-entry synchronous FIFO of fetch_entry_t with a flush input. It is instantiated once in fetch_ctrl.
- inst_mem stays external and is connected by the parent core.

Test Plan:
- Reset, then i_ready = 1 with inst_mem preloaded at 0x0/0x4/0x8/0xc -> o_imem_addr runs 000, 004, 008, 00c on consecutive cycles; o_pc 0x0, 0x4, 0x8, 0xc with matching o_inst, one per cycle after 1-cycle latency.
- i_ready = 0 for 5 cycles after reset -> queue fills at 2 entries (pc 0x0, 0x4); o_imem_addr holds 008; o_pc stays 0x0 throughout; on release, 0x0, 0x4, 0x8 are delivered back-to-back.
- Redirect to 0x100 while the queue is full -> o_valid = 0 the next cycle; the next delivered o_pc is 0x100; entries 0x0/0x4 never appear.
- Redirect to 0x102 -> one entry with o_pc = 0x102, o_fault = 1, o_inst = 0; no further pushes; a redirect to 0x10 resumes at 0x10.
- Sequential fetch reaches 0x3fc with MEM_SIZE = 1024 -> 0x3fc is delivered normally, then a fault entry appears with o_pc = 0x400.
- i_halt high for 3 cycles mid-stream -> no new o_pc values after the queue drains; o_busy = 0 once drained; fetch resumes at the next sequential PC after i_halt drops.
- i_rst_n low during streaming -> o_valid = 0 the next cycle; fetch restarts at RESET_PC.
